// File: rtl/prsnt_pkg.sv
// prsnt_pkg -- shared definitions for the presence-drive block.
//   prsnt_state_e : 3-bit FSM state encoding used by prsnt_drive
//   TMR_W         : width of the qualification / hold timer (ms_timer)
//   prsnt_level() : prsnt_out level associated with each state
package prsnt_pkg;

    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        ST_LO      = 3'd0,
        ST_DLY_HI  = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_HI      = 3'd3,
        ST_DLY_LO  = 3'd4,
        ST_HOLD_LO = 3'd5
    } prsnt_state_e;

    function automatic logic prsnt_level(input prsnt_state_e st);
        logic lvl;
        case (st)
            ST_HI, ST_DLY_LO, ST_HOLD_HI: lvl = 1'b1;
            default:                      lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/prsnt_drive_ms_timer.sv
// ms_timer -- loadable down-counter in clk_1k ticks.
//   clk_1k     : 1 kHz clock, rising edge
//   cpld_rst_n : asynchronous active-low reset, clears the count
//   load/value : load the count with value on the next edge
//   hold       : freeze the count (takes priority over load)
//   expired    : count is 0 or 1, i.e. it reaches 0 on this edge;
//                the count never wraps below 0
module ms_timer
    import prsnt_pkg::*;
(
    input  logic             clk_1k,
    input  logic             cpld_rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] value,
    input  logic             hold,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk_1k or negedge cpld_rst_n) begin
        if (!cpld_rst_n) begin
            count <= '0;
        end else if (!hold) begin
            if (load) begin
                count <= value;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb expired = (count[TMR_W-1:1] == '0);

endmodule

// File: rtl/prsnt_drive.sv
// prsnt_drive -- qualified, hold-time limited presence level driver.
//   Parameters: ASSERT_DLY / DEASSERT_DLY (qualification cycles),
//               MIN_HOLD (dwell after each change), RST_LEVEL.
//   clk_1k, cpld_rst_n : clock / asynchronous active-low reset
//   req_in    : requested presence level
//   inhibit   : freeze state, timer and outputs
//   prsnt_out : registered presence level
//   busy      : FSM in a transitional state
//   edge_pls  : one-cycle pulse after each prsnt_out change
//   chg_cnt   : saturating change counter, only when the macro
//               PRSNT_DRIVE_CNT_EN is defined; constant 0 otherwise
module prsnt_drive
    import prsnt_pkg::*;
#(
    parameter int ASSERT_DLY   = 2,
    parameter int DEASSERT_DLY = 2,
    parameter int MIN_HOLD     = 4,
    parameter int RST_LEVEL    = 0
) (
    input  logic       clk_1k,
    input  logic       cpld_rst_n,
    input  logic       req_in,
    input  logic       inhibit,
    output logic       prsnt_out,
    output logic       busy,
    output logic       edge_pls,
    output logic [7:0] chg_cnt
);

    // Zero delays / hold times skip the corresponding state entirely.
    localparam prsnt_state_e     RST_ST     = (RST_LEVEL != 0) ? ST_HI : ST_LO;
    localparam prsnt_state_e     RISE_ST    = (MIN_HOLD == 0) ? ST_HI : ST_HOLD_HI;
    localparam prsnt_state_e     FALL_ST    = (MIN_HOLD == 0) ? ST_LO : ST_HOLD_LO;
    localparam logic [TMR_W-1:0] HOLD_VAL   = TMR_W'(MIN_HOLD);
    localparam prsnt_state_e     ARM_HI_ST  = (ASSERT_DLY == 0) ? RISE_ST : ST_DLY_HI;
    localparam logic [TMR_W-1:0] ARM_HI_VAL = (ASSERT_DLY == 0) ? HOLD_VAL : TMR_W'(ASSERT_DLY);
    localparam prsnt_state_e     ARM_LO_ST  = (DEASSERT_DLY == 0) ? FALL_ST : ST_DLY_LO;
    localparam logic [TMR_W-1:0] ARM_LO_VAL = (DEASSERT_DLY == 0) ? HOLD_VAL : TMR_W'(DEASSERT_DLY);

    prsnt_state_e     state, state_nxt;
    logic             tmr_load, tmr_exp;
    logic [TMR_W-1:0] tmr_val;
    logic             prsnt_nxt, edge_nxt;

    ms_timer u_timer (
        .clk_1k     (clk_1k),
        .cpld_rst_n (cpld_rst_n),
        .load       (tmr_load),
        .value      (tmr_val),
        .hold       (inhibit),
        .expired    (tmr_exp)
    );

    // State register; prsnt_out and edge_pls are registered from the
    // next state so they never glitch.
    always_ff @(posedge clk_1k or negedge cpld_rst_n) begin
        if (!cpld_rst_n) begin
            state     <= RST_ST;
            prsnt_out <= (RST_LEVEL != 0);
            edge_pls  <= 1'b0;
        end else begin
            state     <= state_nxt;
            prsnt_out <= prsnt_nxt;
            edge_pls  <= edge_nxt;
        end
    end

    // Next state. A hold that expires while req_in already opposes the
    // output arms the opposite qualification on that same edge rather
    // than spending a cycle in the stable state.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (!inhibit) begin
            case (state)
                ST_LO: begin
                    if (req_in) begin
                        state_nxt = ARM_HI_ST;
                        tmr_load  = 1'b1;
                        tmr_val   = ARM_HI_VAL;
                    end
                end
                ST_DLY_HI: begin
                    if (!req_in) begin
                        state_nxt = ST_LO;
                        tmr_load  = 1'b1;
                    end else if (tmr_exp) begin
                        state_nxt = RISE_ST;
                        tmr_load  = 1'b1;
                        tmr_val   = HOLD_VAL;
                    end
                end
                ST_HOLD_HI: begin
                    if (tmr_exp) begin
                        tmr_load = 1'b1;
                        if (!req_in) begin
                            state_nxt = ARM_LO_ST;
                            tmr_val   = ARM_LO_VAL;
                        end else begin
                            state_nxt = ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (!req_in) begin
                        state_nxt = ARM_LO_ST;
                        tmr_load  = 1'b1;
                        tmr_val   = ARM_LO_VAL;
                    end
                end
                ST_DLY_LO: begin
                    if (req_in) begin
                        state_nxt = ST_HI;
                        tmr_load  = 1'b1;
                    end else if (tmr_exp) begin
                        state_nxt = FALL_ST;
                        tmr_load  = 1'b1;
                        tmr_val   = HOLD_VAL;
                    end
                end
                ST_HOLD_LO: begin
                    if (tmr_exp) begin
                        tmr_load = 1'b1;
                        if (req_in) begin
                            state_nxt = ARM_HI_ST;
                            tmr_val   = ARM_HI_VAL;
                        end else begin
                            state_nxt = ST_LO;
                        end
                    end
                end
                default: begin
                    state_nxt = RST_ST;
                    tmr_load  = 1'b1;
                end
            endcase
        end
    end

    // Outputs. While inhibited state_nxt == state, so no edge can occur.
    always_comb begin
        busy      = (state != ST_LO) && (state != ST_HI);
        prsnt_nxt = prsnt_level(state_nxt);
        edge_nxt  = prsnt_nxt ^ prsnt_out;
    end

`ifdef PRSNT_DRIVE_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk_1k or negedge cpld_rst_n) begin
        if (!cpld_rst_n) begin
            cnt_q <= '0;
        end else if (edge_nxt && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign chg_cnt = cnt_q;
`else
    assign chg_cnt = '0;
`endif

endmodule

// File: tb/tb_prsnt_drive.sv
// tb_prsnt_drive -- directed self-checking bench for prsnt_drive with
// default parameters. Inputs change on the falling edge; outputs are
// checked on the following falling edge.
module tb_prsnt_drive;

`ifdef PRSNT_DRIVE_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic       clk_1k = 1'b0;
    logic       cpld_rst_n;
    logic       req_in;
    logic       inhibit;
    logic       prsnt_out;
    logic       busy;
    logic       edge_pls;
    logic [7:0] chg_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    prsnt_drive #(
        .ASSERT_DLY   (2),
        .DEASSERT_DLY (2),
        .MIN_HOLD     (4),
        .RST_LEVEL    (0)
    ) dut (
        .clk_1k     (clk_1k),
        .cpld_rst_n (cpld_rst_n),
        .req_in     (req_in),
        .inhibit    (inhibit),
        .prsnt_out  (prsnt_out),
        .busy       (busy),
        .edge_pls   (edge_pls),
        .chg_cnt    (chg_cnt)
    );

    always #5 clk_1k = ~clk_1k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_cnt(input int v);
        return (CNT_EN != 0) ? ((v > 255) ? 255 : v) : 0;
    endfunction

    initial begin
        int edges;

        // Reset state
        cpld_rst_n = 1'b0;
        req_in     = 1'b0;
        inhibit    = 1'b0;
        #1;
        check("rst_prsnt", prsnt_out, 0);
        check("rst_busy",  busy,      0);
        check("rst_edge",  edge_pls,  0);
        check("rst_cnt",   chg_cnt,   0);
        repeat (2) @(negedge clk_1k);
        cpld_rst_n = 1'b1;
        repeat (2) @(negedge clk_1k);

        // Qualified rise: req sampled high from edge k
        req_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_1k);
            check($sformatf("rise_prsnt_k%0d", i), prsnt_out, (i >= 2));
            check($sformatf("rise_edge_k%0d", i),  edge_pls,  (i == 2));
            check($sformatf("rise_busy_k%0d", i),  busy,      (i < 6));
        end
        check("rise_cnt", chg_cnt, exp_cnt(1));
        req_in = 1'b0;
        repeat (14) @(negedge clk_1k);
        check("fall_prsnt", prsnt_out, 0);
        check("fall_busy",  busy,      0);
        check("fall_cnt",   chg_cnt,   exp_cnt(2));

        // One-cycle request: aborted qualification
        req_in = 1'b1;
        @(negedge clk_1k);
        req_in = 1'b0;
        check("short_busy_k0", busy, 1);
        edges = 0;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk_1k);
            if (edge_pls) edges++;
            check($sformatf("short_prsnt_k%0d", i), prsnt_out, 0);
        end
        check("short_busy_end", busy, 0);
        check("short_edges", edges, 0);

        // Request drops right after the rise at edge r
        req_in = 1'b1;
        repeat (3) @(negedge clk_1k);
        edges = edge_pls ? 1 : 0;
        check("drop_rise", prsnt_out, 1);
        req_in = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk_1k);
            if (edge_pls) edges++;
            check($sformatf("drop_prsnt_r%0d", j), prsnt_out, (j < 6));
            check($sformatf("drop_edge_r%0d", j),  edge_pls,  (j == 6));
        end
        check("drop_edges", edges, 2);
        check("drop_busy",  busy,  0);
        check("drop_cnt",   chg_cnt, exp_cnt(4));

        // Inhibit for 10 edges inside DLY_HI
        req_in = 1'b1;
        @(negedge clk_1k);
        inhibit = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk_1k);
            check($sformatf("inh_prsnt_k%0d", i), prsnt_out, (i >= 12));
            check($sformatf("inh_edge_k%0d", i),  edge_pls,  (i == 12));
            if (i <= 10) check($sformatf("inh_busy_k%0d", i), busy, 1);
            if (i == 10) inhibit = 1'b0;
        end
        req_in = 1'b0;
        repeat (20) @(negedge clk_1k);
        check("inh_end_prsnt", prsnt_out, 0);
        check("inh_end_busy",  busy,      0);

        // Asynchronous reset in HOLD_HI
        req_in = 1'b1;
        repeat (4) @(negedge clk_1k);
        check("hold_prsnt", prsnt_out, 1);
        check("hold_busy",  busy,      1);
        #2 cpld_rst_n = 1'b0;
        #1;
        check("arst_prsnt", prsnt_out, 0);
        check("arst_busy",  busy,      0);
        check("arst_edge",  edge_pls,  0);
        check("arst_cnt",   chg_cnt,   0);
        @(negedge clk_1k);
        cpld_rst_n = 1'b1;
        @(negedge clk_1k);
        check("rel_busy",  busy,      1);
        check("rel_prsnt", prsnt_out, 0);
        repeat (2) @(negedge clk_1k);
        check("rel_rise",  prsnt_out, 1);
        req_in = 1'b0;
        repeat (20) @(negedge clk_1k);
        check("rel_cnt", chg_cnt, exp_cnt(2));

        // 300 qualified toggles, 12 cycles per rise/fall pair
        for (int p = 0; p < 150; p++) begin
            req_in = 1'b1;
            repeat (6) @(negedge clk_1k);
            req_in = 1'b0;
            repeat (6) @(negedge clk_1k);
            if (p == 49) check("tog_cnt_mid", chg_cnt, exp_cnt(102));
        end
        repeat (4) @(negedge clk_1k);
        check("tog_prsnt", prsnt_out, 0);
        check("tog_cnt",   chg_cnt,   exp_cnt(302));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prsnt_drive.md
PRSNT_DRIVE -- requirements
Module: prsnt_drive

Interface
REQ-001 SHALL have parameter ASSERT_DLY, default 2; qualification delay in clk_1k cycles before prsnt_out rises (0..255).
REQ-002 SHALL have parameter DEASSERT_DLY, default 2; qualification delay in clk_1k cycles before prsnt_out falls (0..255).
REQ-003 SHALL have parameter MIN_HOLD, default 4; minimum dwell in cycles after any prsnt_out change (0..255).
REQ-004 SHALL have parameter RST_LEVEL, default 0; prsnt_out level during and after reset.
REQ-005 clk_1k  input  1  1 kHz free-running clock, all logic on rising edge.
REQ-006 cpld_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_in  input  1  requested presence level from internal logic, synchronous to clk_1k.
REQ-008 inhibit  input  1  freeze: state, timer and outputs hold while high.
REQ-009 prsnt_out  output  1  registered, glitch-free presence level driven to the remote debouncer.
REQ-010 busy  output  1  high in any transitional state (not LO, not HI).
REQ-011 edge_pls  output  1  one-cycle pulse on the cycle prsnt_out changes.
REQ-012 chg_cnt  output  8  count of prsnt_out changes (see Configuration).

Function
REQ-013 FSM states SHALL be LO, DLY_HI, HOLD_HI, HI, DLY_LO, HOLD_LO; prsnt_out=0 in LO/DLY_HI/HOLD_LO, 1 in HI/DLY_LO/HOLD_HI.
REQ-014 LO with req_in=1 at edge k SHALL go to DLY_HI loading timer=ASSERT_DLY; if ASSERT_DLY=0, go directly to HOLD_HI with prsnt_out rising at edge k.
REQ-015 DLY_HI SHALL decrement timer each edge; prsnt_out SHALL rise at edge k+ASSERT_DLY iff req_in=1 at every edge k..k+ASSERT_DLY; entering HOLD_HI loads timer=MIN_HOLD.
REQ-016 DLY_HI with req_in=0 at any edge SHALL return to LO, no prsnt_out change, no edge_pls.
REQ-017 HOLD_HI SHALL ignore req_in, decrement timer, go to HI when timer expires (MIN_HOLD edges after rise); MIN_HOLD=0 goes straight to HI.
REQ-018 HI/DLY_LO/HOLD_LO SHALL mirror REQ-014..017 with req_in=0, DEASSERT_DLY and falling prsnt_out.
REQ-019 edge_pls SHALL be high exactly for the cycle following each prsnt_out change edge, never otherwise.
REQ-020 inhibit=1 SHALL freeze state and timer; a transition due on the same edge SHALL be deferred until the first edge with inhibit=0.
REQ-021 Timer SHALL be 8 bits, never underflow; reaching 0 ends the state.

Reset
REQ-022 cpld_rst_n=0 SHALL asynchronously set state=HI if RST_LEVEL=1 else LO, prsnt_out=RST_LEVEL, timer=0, busy=0, edge_pls=0, chg_cnt=0, including mid-transition.
REQ-023 First edge after reset release SHALL evaluate req_in normally.

Configuration
REQ-024 Macro PRSNT_DRIVE_CNT_EN defined: chg_cnt SHALL increment on each prsnt_out change, saturating at 255.
REQ-025 Macro undefined: chg_cnt SHALL be constant 0, no counter register.

Structure
REQ-026 State encodings (3-bit) and 8-bit timer width constant SHALL live in shared package prsnt_pkg.
REQ-027 Loadable 8-bit down-counter SHALL be sub-module ms_timer (load, value, hold, expired).

Verification (defaults ASSERT_DLY=2, DEASSERT_DLY=2, MIN_HOLD=4, RST_LEVEL=0)
REQ-028 req_in 0->1 first sampled edge k, held -> prsnt_out=1 from edge k+2, edge_pls one cycle, busy high through k+6, HI at k+6.
REQ-029 req_in high for one cycle -> prsnt_out stays 0, edge_pls never, FSM back to LO after 1 edge.
REQ-030 req_in drops the cycle after rise at edge r -> prsnt_out held 1 until r+4, falls at r+6, edge_pls twice total.
REQ-031 inhibit high 10 cycles starting inside DLY_HI -> rise delayed exactly 10 cycles versus REQ-028.
REQ-032 cpld_rst_n low mid HOLD_HI -> prsnt_out=0, busy=0, chg_cnt=0 immediately, no clock required.
REQ-033 300 qualified toggles -> chg_cnt=255 with PRSNT_DRIVE_CNT_EN, 0 without.
